// File: rtl/secded_pkg.sv
// Shared types, constants and the combinational SECDED(16,11) decode function.
// The error-counter feature (ERR_COUNT_EN) uses the WR_SC/WR_DC states and counter addresses.
package secded_pkg;

   typedef enum logic [3:0] {
      IDLE,
      RD_LO,
      RD_HI,
      DECODE,
      WR_LO,
      WR_HI,
      WR_SC,
      WR_DC,
      DONE
   } state_t;

   localparam logic [1:0] FLG_NONE = 2'b00;
   localparam logic [1:0] FLG_SGL  = 2'b01;
   localparam logic [1:0] FLG_DBL  = 2'b10;

   localparam int unsigned IN_BASE_DEF  = 30;
   localparam int unsigned OUT_BASE_DEF = 0;
   localparam int unsigned SGL_CNT_ADDR = 60;
   localparam int unsigned DBL_CNT_ADDR = 61;

   // Returns the packed output word {flags, 3'b000, d[11:1]}.
   function automatic logic [15:0] secded_decode(input logic [15:0] w);
      logic [3:0]  s;
      logic        p;
      logic [15:0] c;
      logic [1:0]  f;
      s = '0;
      for (int k = 1; k < 16; k++) begin
         if (w[k]) s = s ^ 4'(k);
      end
      p = ^w;
      c = w;
      if (p) begin
         f = FLG_SGL;
         if (s != 4'd0) c[s] = ~c[s];
      end else if (s != 4'd0) begin
         f = FLG_DBL;
      end else begin
         f = FLG_NONE;
      end
      return {f, 3'b000, c[15:13], c[12:9], c[7:5], c[3]};
   endfunction

endpackage

// File: rtl/secded_if.sv
// Byte-wide data-memory bus between the decoder engine (master) and its memory (slave).
interface secded_if #(
   parameter int unsigned AW = 8
) ();
   logic [AW-1:0] addr;
   logic [7:0]    wdata;
   logic [7:0]    rdata;
   logic          we;

   modport master (output addr, output wdata, output we, input rdata);
   modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/data_mem.sv
// 2**AW x 8 byte memory: combinational read, synchronous write. Contents are never reset.
module data_mem #(
   parameter int unsigned AW = 8
) (
   input logic     clk,
   secded_if.slave bus
);
   logic [7:0] core [0:2**AW-1];

   always_ff @(posedge clk) begin
      if (bus.we) core[bus.addr] <= bus.wdata;
   end

   assign bus.rdata = core[bus.addr];

endmodule

// File: rtl/top_level.sv
// SECDED(16,11) decoder engine: reads NUM_WORDS codewords from dm1, writes flagged messages, then done.
// Define ERR_COUNT_EN to also store single/double error counts at bytes 60/61 before done.
module top_level
   import secded_pkg::*;
#(
   parameter int unsigned NUM_WORDS = 15,
   parameter int unsigned IN_BASE   = IN_BASE_DEF,
   parameter int unsigned OUT_BASE  = OUT_BASE_DEF,
   parameter int unsigned AW        = 8
) (
   input  logic clk,
   input  logic reset,
   output logic done
);
   localparam int unsigned IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   secded_if #(.AW(AW)) mem_bus ();

   data_mem #(.AW(AW)) dm1 (
      .clk (clk),
      .bus (mem_bus)
   );

   state_t        r_state;
   logic [IW-1:0] r_idx;
   logic [15:0]   r_cw;
   logic [15:0]   r_res;
   logic          r_done;
`ifdef ERR_COUNT_EN
   logic [7:0]    r_sgl_cnt;
   logic [7:0]    r_dbl_cnt;
`endif

   logic [AW-1:0] w_addr;
   logic [7:0]    w_wdata;
   logic          w_we;
   logic [15:0]   w_dec;
   logic [AW-1:0] w_in_addr;
   logic [AW-1:0] w_out_addr;

   assign w_dec      = secded_decode(r_cw);
   assign w_in_addr  = AW'(IN_BASE + 2 * int'(r_idx));
   assign w_out_addr = AW'(OUT_BASE + 2 * int'(r_idx));

   always_comb begin
      w_addr  = '0;
      w_wdata = '0;
      w_we    = 1'b0;
      case (r_state)
         RD_LO: w_addr = w_in_addr;
         RD_HI: w_addr = w_in_addr + AW'(1);
         WR_LO: begin
            w_addr  = w_out_addr;
            w_wdata = r_res[7:0];
            w_we    = 1'b1;
         end
         WR_HI: begin
            w_addr  = w_out_addr + AW'(1);
            w_wdata = r_res[15:8];
            w_we    = 1'b1;
         end
`ifdef ERR_COUNT_EN
         WR_SC: begin
            w_addr  = AW'(SGL_CNT_ADDR);
            w_wdata = r_sgl_cnt;
            w_we    = 1'b1;
         end
         WR_DC: begin
            w_addr  = AW'(DBL_CNT_ADDR);
            w_wdata = r_dbl_cnt;
            w_we    = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign mem_bus.addr  = w_addr;
   assign mem_bus.wdata = w_wdata;
   assign mem_bus.we    = w_we;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_cw      <= '0;
         r_res     <= '0;
         r_done    <= 1'b0;
`ifdef ERR_COUNT_EN
         r_sgl_cnt <= '0;
         r_dbl_cnt <= '0;
`endif
      end else begin
         case (r_state)
            IDLE:  r_state <= RD_LO;
            RD_LO: begin
               r_cw[7:0] <= mem_bus.rdata;
               r_state   <= RD_HI;
            end
            RD_HI: begin
               r_cw[15:8] <= mem_bus.rdata;
               r_state    <= DECODE;
            end
            DECODE: begin
               r_res   <= w_dec;
`ifdef ERR_COUNT_EN
               if (w_dec[15:14] == FLG_SGL) r_sgl_cnt <= r_sgl_cnt + 8'd1;
               if (w_dec[15:14] == FLG_DBL) r_dbl_cnt <= r_dbl_cnt + 8'd1;
`endif
               r_state <= WR_LO;
            end
            WR_LO: r_state <= WR_HI;
            WR_HI: begin
               if (r_idx == IW'(NUM_WORDS - 1)) begin
`ifdef ERR_COUNT_EN
                  r_state <= WR_SC;
`else
                  r_state <= DONE;
                  r_done  <= 1'b1;
`endif
               end else begin
                  r_idx   <= r_idx + IW'(1);
                  r_state <= RD_LO;
               end
            end
`ifdef ERR_COUNT_EN
            WR_SC: r_state <= WR_DC;
            WR_DC: begin
               r_state <= DONE;
               r_done  <= 1'b1;
            end
`endif
            DONE:    r_state <= DONE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign done = r_done;

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: table of codewords with expected outputs, plus abort/rerun.
module tb_top_level;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic done;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef ERR_COUNT_EN
   localparam int LAT = 78;
`else
   localparam int LAT = 76;
`endif

   always #5 clk = ~clk;

   top_level dut (
      .clk   (clk),
      .reset (reset),
      .done  (done)
   );

   secded_if #(.AW(8)) mon ();
   assign mon.addr  = dut.mem_bus.addr;
   assign mon.wdata = dut.mem_bus.wdata;
   assign mon.we    = dut.mem_bus.we;
   assign mon.rdata = dut.mem_bus.rdata;

   typedef struct {
      logic [15:0] cw;
      logic [15:0] exp;
   } vec_t;

   vec_t vt [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Builds a valid codeword from the 11 data bits d[11:1].
   function automatic logic [15:0] enc(input logic [10:0] dv);
      logic [15:0] w;
      logic [3:0]  s;
      w = '0;
      w[3]     = dv[0];
      w[7:5]   = dv[3:1];
      w[15:9]  = dv[10:4];
      s = '0;
      for (int k = 1; k < 16; k++) if (w[k]) s = s ^ 4'(k);
      w[1] = s[0];
      w[2] = s[1];
      w[4] = s[2];
      w[8] = s[3];
      w[0] = ^w[15:1];
      return w;
   endfunction

   task automatic set_enc(input int i, input logic [10:0] dv, input logic [15:0] flips,
                          input logic [1:0] flg);
      vt[i].cw  = enc(dv) ^ flips;
      vt[i].exp = {flg, 3'b000, dv};
   endtask

   task automatic preload();
      for (int i = 0; i < 15; i++) begin
         dut.dm1.core[30 + 2 * i]     = vt[i].cw[7:0];
         dut.dm1.core[30 + 2 * i + 1] = vt[i].cw[15:8];
         dut.dm1.core[2 * i]          = 8'hEE;
         dut.dm1.core[2 * i + 1]      = 8'hEE;
      end
      dut.dm1.core[60] = 8'hA5;
      dut.dm1.core[61] = 8'h5A;
   endtask

   task automatic release_and_wait(output int cyc);
      @(negedge clk);
      reset = 1'b1;
      cyc = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done) break;
      end
   endtask

   task automatic check_outputs(input string tag);
      for (int i = 0; i < 15; i++) begin
         chk($sformatf("%s_word%0d", tag, i),
             {16'h0, dut.dm1.core[2 * i + 1], dut.dm1.core[2 * i]}, {16'h0, vt[i].exp});
      end
`ifdef ERR_COUNT_EN
      chk({tag, "_sgl_cnt"}, {24'h0, dut.dm1.core[60]}, 32'd10);
      chk({tag, "_dbl_cnt"}, {24'h0, dut.dm1.core[61]}, 32'd3);
`else
      chk({tag, "_byte60"}, {24'h0, dut.dm1.core[60]}, 32'hA5);
      chk({tag, "_byte61"}, {24'h0, dut.dm1.core[61]}, 32'h5A);
`endif
   endtask

   initial begin
      int   cyc;
      logic hold_bad;
      logic wr_seen;

      vt[0]  = '{cw: 16'hFFFF, exp: 16'h07FF};
      vt[1]  = '{cw: 16'h0020, exp: 16'h4000};
      vt[2]  = '{cw: 16'h0040, exp: 16'h4000};
      vt[3]  = '{cw: 16'h0001, exp: 16'h4000};
      vt[4]  = '{cw: 16'h0028, exp: 16'h8003};
      set_enc(5,  11'h555, 16'h0000, 2'b00);
      set_enc(6,  11'h123, 16'h0008, 2'b01);
      set_enc(7,  11'h7A0, 16'h0080, 2'b01);
      set_enc(8,  11'h00F, 16'h0400, 2'b01);
      set_enc(9,  11'h3C3, 16'h8000, 2'b01);
      set_enc(10, 11'h2AA, 16'h0001, 2'b01);
      set_enc(11, 11'h600, 16'h0100, 2'b01);
      set_enc(12, 11'h0F0, 16'h1000, 2'b01);
      set_enc(13, 11'h1FF, 16'h0006, 2'b10);
      set_enc(14, 11'h444, 16'h0011, 2'b10);

      #2 reset = 1'b0;
      preload();
      repeat (3) @(negedge clk);
      chk("reset_done_low", {31'h0, done}, 32'd0);

      release_and_wait(cyc);
      chk("done_latency", cyc, LAT);
      chk("done_high", {31'h0, done}, 32'd1);
      check_outputs("run1");

      hold_bad = 1'b0;
      wr_seen  = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done !== 1'b1) hold_bad = 1'b1;
         if (mon.we !== 1'b0) wr_seen = 1'b1;
      end
      chk("done_hold", {31'h0, hold_bad}, 32'd0);
      chk("no_write_after_done", {31'h0, wr_seen}, 32'd0);

      // Abort right after word 3's low byte is written.
      @(negedge clk);
      reset = 1'b0;
      preload();
      @(negedge clk);
      reset = 1'b1;
      repeat (20) @(posedge clk);
      #1 reset = 1'b0;
      #1 chk("abort_done_low", {31'h0, done}, 32'd0);
      repeat (3) @(negedge clk);
      chk("abort_w2_hi", {24'h0, dut.dm1.core[5]}, {24'h0, vt[2].exp[15:8]});
      chk("abort_w3_lo", {24'h0, dut.dm1.core[6]}, {24'h0, vt[3].exp[7:0]});
      chk("abort_w3_hi", {24'h0, dut.dm1.core[7]}, 32'hEE);
      chk("abort_w4_lo", {24'h0, dut.dm1.core[8]}, 32'hEE);
      chk("abort_still_low", {31'h0, done}, 32'd0);

      release_and_wait(cyc);
      chk("rerun_latency", cyc, LAT);
      chk("rerun_done_high", {31'h0, done}, 32'd1);
      check_outputs("rerun");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
